// File: rtl/fifo_serial_tx.sv
// Serial transmitter that pulls bytes from a one-cycle-latency FIFO and sends 8N1 frames.
// Define FIFO_TX_PARITY_EN to insert an even-parity bit after data bit 7 (8E1 frames).
module fifo_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] BUFFER_OUT,
    input  logic       EMPTY,
    input  logic       ENABLE,
    output logic       RD_EN,
    output logic       TX,
    output logic       BUSY,
    output logic       BYTE_DONE,
    output logic [7:0] BYTE_CNT
);
    localparam int unsigned BAUD_W = 8;
    localparam int unsigned BIT_W  = 3;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef FIFO_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        STOP   = 3'd5,
        PARITY = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              tx_q, tx_d;
    logic              rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              baud_tc;
`ifdef FIFO_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign baud_tc = (baud_q == BAUD_LAST);

    // Next-state logic; outputs are decoded from the next state so the flops line up with the state.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef FIFO_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (ENABLE && !EMPTY) state_d = FETCH;
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = BUFFER_OUT;
`ifdef FIFO_TX_PARITY_EN
                par_d   = ^BUFFER_OUT;
`endif
                baud_d  = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == BIT_W'(7)) begin
`ifdef FIFO_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef FIFO_TX_PARITY_EN
            PARITY: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = (ENABLE && !EMPTY) ? FETCH : IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef FIFO_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
        rd_d   = (state_d == FETCH);
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FIFO_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign TX        = tx_q;
    assign RD_EN     = rd_q;
    assign BUSY      = busy_q;
    assign BYTE_DONE = done_q;
    assign BYTE_CNT  = cnt_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx: FIFO model, frame scoreboard and a per-cycle line monitor.
module tb_fifo_serial_tx;
    localparam int C = 4;
`ifdef FIFO_TX_PARITY_EN
    localparam int FRAME_LEN = 11 * C;
`else
    localparam int FRAME_LEN = 10 * C;
`endif

    logic       CLK;
    logic       RST;
    logic [7:0] BUFFER_OUT;
    logic       EMPTY;
    logic       ENABLE;
    logic       RD_EN;
    logic       TX;
    logic       BUSY;
    logic       BYTE_DONE;
    logic [7:0] BYTE_CNT;

    fifo_serial_tx #(.CLKS_PER_BIT(C)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .BUFFER_OUT (BUFFER_OUT),
        .EMPTY      (EMPTY),
        .ENABLE     (ENABLE),
        .RD_EN      (RD_EN),
        .TX         (TX),
        .BUSY       (BUSY),
        .BYTE_DONE  (BYTE_DONE),
        .BYTE_CNT   (BYTE_CNT)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] sb[$];
    int         gaps[$];
    bit         load_pending = 1'b0;
    logic [7:0] pend_byte = 8'h00;
    bit         in_frame = 1'b0;
    int         fidx = 0;
    logic [7:0] cur_byte = 8'h00;
    int         frames_started = 0;
    int         rd_cnt = 0;
    int         done_cnt = 0;
    bit         have_end = 1'b0;
    int         end_cyc = 0;
    bit         ok;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic exp_tx(input logic [7:0] b, input int idx);
        int slot;
        slot = idx / C;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[3'(slot - 1)];
`ifdef FIFO_TX_PARITY_EN
        if (slot == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] b, input bit expected);
        fifo_q.push_back(b);
        EMPTY = 1'b0;
        if (expected) sb.push_back(b);
    endtask

    // One clock: FIFO model reacts to RD_EN, monitor checks the line against the scoreboard.
    task automatic cycle();
        @(negedge CLK);
        cyc++;
        if (load_pending) begin
            BUFFER_OUT   = pend_byte;
            load_pending = 1'b0;
        end
        if (RST) begin
            in_frame = 1'b0;
            have_end = 1'b0;
        end else begin
            if (RD_EN === 1'b1) begin
                rd_cnt++;
                check1("rd_en_while_empty", EMPTY, 1'b0);
                if (fifo_q.size() > 0) begin
                    pend_byte    = fifo_q.pop_front();
                    BUFFER_OUT   = ~pend_byte;
                    load_pending = 1'b1;
                end
                EMPTY = (fifo_q.size() == 0);
            end
            if (BYTE_DONE === 1'b1) done_cnt++;
            if (!in_frame && TX === 1'b0) begin
                frames_started++;
                if (have_end) gaps.push_back(cyc - end_cyc - 1);
                check1("unexpected_frame", sb.size() != 0, 1'b1);
                cur_byte = (sb.size() != 0) ? sb.pop_front() : 8'h00;
                in_frame = 1'b1;
                fidx     = 0;
            end
            if (in_frame) begin
                check1("tx_bit", TX, exp_tx(cur_byte, fidx));
                check1("byte_done_frame", BYTE_DONE, fidx == FRAME_LEN - 1);
                check1("busy_frame", BUSY, 1'b1);
                fidx++;
                if (fidx == FRAME_LEN) begin
                    in_frame = 1'b0;
                    have_end = 1'b1;
                    end_cyc  = cyc;
                end
            end else begin
                check1("byte_done_idle", BYTE_DONE, 1'b0);
            end
        end
    endtask

    task automatic do_reset();
        RST    = 1'b1;
        ENABLE = 1'b0;
        cycle();
        RST = 1'b0;
        fifo_q.delete();
        sb.delete();
        gaps.delete();
        EMPTY          = 1'b1;
        load_pending   = 1'b0;
        frames_started = 0;
        rd_cnt         = 0;
        done_cnt       = 0;
    endtask

    task automatic run_until_idle(input int max, output bit done);
        bit seen;
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < max; i++) begin
            cycle();
            if (BUSY === 1'b1) seen = 1'b1;
            else if (seen) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_until_pos(input int frame_no, input int idx, input int max, output bit done);
        done = 1'b0;
        for (int i = 0; i < max; i++) begin
            cycle();
            if (frames_started == frame_no && in_frame && fidx == idx) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_tx"}, TX, 1'b1);
        check1({tag, "_rd_en"}, RD_EN, 1'b0);
        check1({tag, "_busy"}, BUSY, 1'b0);
        check1({tag, "_byte_done"}, BYTE_DONE, 1'b0);
        check8({tag, "_byte_cnt"}, BYTE_CNT, 8'h00);
    endtask

    initial begin
        CLK        = 1'b0;
        RST        = 1'b1;
        ENABLE     = 1'b0;
        EMPTY      = 1'b1;
        BUFFER_OUT = 8'h00;

        // Reset state
        do_reset();
        check_reset_outputs("reset");

        // Single byte 0xF0
        push(8'hF0, 1'b1);
        ENABLE = 1'b1;
        run_until_idle(200, ok);
        check1("single_idle_timeout", ok, 1'b1);
        checkn("single_rd_pulses", rd_cnt, 1);
        checkn("single_byte_done", done_cnt, 1);
        check8("single_byte_cnt", BYTE_CNT, 8'h01);
        check1("single_busy_low", BUSY, 1'b0);
        checkn("single_sb_left", sb.size(), 0);

        // Eight back-to-back bytes
        do_reset();
        for (int i = 0; i < 8; i++) push(8'hF0 + 8'(i), 1'b1);
        ENABLE = 1'b1;
        run_until_idle(1000, ok);
        check1("burst_idle_timeout", ok, 1'b1);
        checkn("burst_rd_pulses", rd_cnt, 8);
        checkn("burst_byte_done", done_cnt, 8);
        check8("burst_byte_cnt", BYTE_CNT, 8'h08);
        checkn("burst_sb_left", sb.size(), 0);
        checkn("burst_gap_count", gaps.size(), 7);
        foreach (gaps[i]) checkn("burst_gap_len", gaps[i], 2);
        repeat (5) cycle();
        check1("burst_stays_idle", BUSY, 1'b0);

        // ENABLE dropped during the 0xF3 data bits
        do_reset();
        for (int i = 0; i < 8; i++) push(8'hF0 + 8'(i), i < 4);
        ENABLE = 1'b1;
        run_until_pos(4, 2 * C + 1, 1000, ok);
        check1("drop_reach_timeout", ok, 1'b1);
        ENABLE = 1'b0;
        run_until_idle(200, ok);
        check1("drop_idle_timeout", ok, 1'b1);
        repeat (20) cycle();
        checkn("drop_rd_pulses", rd_cnt, 4);
        checkn("drop_byte_done", done_cnt, 4);
        check8("drop_byte_cnt", BYTE_CNT, 8'h04);
        checkn("drop_fifo_left", fifo_q.size(), 4);
        checkn("drop_sb_left", sb.size(), 0);

        // Reset during data bit 3
        do_reset();
        push(8'hF0, 1'b1);
        ENABLE = 1'b1;
        run_until_pos(1, 4 * C + 1, 200, ok);
        check1("abort_reach_timeout", ok, 1'b1);
        do_reset();
        check_reset_outputs("abort");
        repeat (30) cycle();
        checkn("abort_frames", frames_started, 0);
        checkn("abort_byte_done", done_cnt, 0);
        checkn("abort_rd_pulses", rd_cnt, 0);
        check1("abort_tx_idle", TX, 1'b1);
        check8("abort_byte_cnt", BYTE_CNT, 8'h00);

        // Odd then even parity patterns (parity slot only in the macro build)
        do_reset();
        push(8'hF1, 1'b1);
        push(8'hF0, 1'b1);
        push(8'h3C, 1'b1);
        ENABLE = 1'b1;
        run_until_idle(600, ok);
        check1("par_idle_timeout", ok, 1'b1);
        checkn("par_byte_done", done_cnt, 3);
        check8("par_byte_cnt", BYTE_CNT, 8'h03);
        checkn("par_sb_left", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
